// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32I hazard/pipeline-control unit.
// The cause enum is the single decision that drives every control output.
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int X0         = 0;
    localparam int FLUSH_W    = 3;

    typedef enum logic [2:0] {
        NONE,
        FREEZE,
        STALL_LOAD,
        STALL_BR_EX,
        STALL_BR_MEM,
        REDIRECT,
        FLUSH_TAIL
    } hazard_cause_e;

endpackage

// File: rtl/hazard_src_match.sv
// Compares one producer destination register against all ID source ports.
// Register x0 never produces a hazard; unused ports never match.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = REG_AW_DEF
) (
    input  logic [NUM_SRC*REG_AW-1:0] rs,
    input  logic [NUM_SRC-1:0]        rs_used,
    input  logic [REG_AW-1:0]         rd,
    output logic                      hit
);

    logic [NUM_SRC-1:0] port_hit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
        assign port_hit[i] = rs_used[i] && (rd != REG_AW'(X0)) &&
                             (rs[i*REG_AW +: REG_AW] == rd);
    end

    assign hit = |port_hit;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard detection, memory freeze, redirect flush sequencing and
// saturating stall/freeze counters for the five-stage RV32I pipeline.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int REG_AW      = REG_AW_DEF,
    parameter int IMEM_LAT    = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      idex_reg_write,
    input  logic                      idex_mem_read,
    input  logic [REG_AW-1:0]         idex_rd,
    input  logic                      exmem_mem_read,
    input  logic [REG_AW-1:0]         exmem_rd,
    input  logic [NUM_SRC*REG_AW-1:0] ifid_rs,
    input  logic [NUM_SRC-1:0]        ifid_rs_used,
    input  logic                      id_needs_operands,
    input  logic                      jump_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_write,
    output logic                      ifid_write,
    output logic                      idex_write,
    output logic                      exmem_write,
    output logic                      idex_bubble,
    output logic                      ifid_flush,
    output logic                      mem_timeout,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [CNT_W-1:0]          freeze_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic                hit_ex, hit_mem;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    hazard_cause_e       cause;
    logic                is_stall;

    hazard_src_match #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) u_match_ex (
        .rs(ifid_rs), .rs_used(ifid_rs_used), .rd(idex_rd), .hit(hit_ex)
    );

    hazard_src_match #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) u_match_mem (
        .rs(ifid_rs), .rs_used(ifid_rs_used), .rd(exmem_rd), .hit(hit_mem)
    );

    // Highest-priority cause wins; jump_taken is dropped while ID operands are stalled.
    always_comb begin
        cause = NONE;
        if (mem_req && !mem_ready)                                cause = FREEZE;
        else if (idex_mem_read && hit_ex)                         cause = STALL_LOAD;
        else if (idex_reg_write && id_needs_operands && hit_ex)   cause = STALL_BR_EX;
        else if (exmem_mem_read && id_needs_operands && hit_mem)  cause = STALL_BR_MEM;
        else if (jump_taken)                                      cause = REDIRECT;
        else if (flush_cnt != '0)                                 cause = FLUSH_TAIL;
    end

    assign is_stall = (cause == STALL_LOAD) || (cause == STALL_BR_EX) ||
                      (cause == STALL_BR_MEM);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        case (cause)
            FREEZE: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
            end
            STALL_LOAD, STALL_BR_EX, STALL_BR_MEM: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            REDIRECT, FLUSH_TAIL: ifid_flush = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt     <= '0;
            wait_cnt      <= '0;
            mem_timeout   <= 1'b0;
            stall_cycles  <= '0;
            freeze_cycles <= '0;
        end else begin
            case (cause)
                REDIRECT:   flush_cnt <= FLUSH_W'(IMEM_LAT);
                FLUSH_TAIL: flush_cnt <= flush_cnt - 1'b1;
                default: ;
            endcase

            // Timeout is flagged on the edge where the consecutive count reaches the limit.
            if (cause == FREEZE) begin
                if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
                    wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1))
                    mem_timeout <= 1'b1;
                if (freeze_cycles != '1)
                    freeze_cycles <= freeze_cycles + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (is_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed and randomized check of hazard_ctrl_unit against a behavioural model.
module tb_hazard_ctrl_unit;

    localparam int NUM_SRC     = 2;
    localparam int REG_AW      = 5;
    localparam int IMEM_LAT    = 2;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 6;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      idex_reg_write, idex_mem_read, exmem_mem_read;
    logic [REG_AW-1:0]         idex_rd, exmem_rd;
    logic [NUM_SRC*REG_AW-1:0] ifid_rs;
    logic [NUM_SRC-1:0]        ifid_rs_used;
    logic                      id_needs_operands, jump_taken, mem_req, mem_ready;
    logic                      pc_write, ifid_write, idex_write, exmem_write;
    logic                      idex_bubble, ifid_flush, mem_timeout;
    logic [CNT_W-1:0]          stall_cycles, freeze_cycles;

    int n_pass = 0;
    int n_total = 0;

    hazard_ctrl_unit #(
        .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .IMEM_LAT(IMEM_LAT),
        .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd),
        .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used),
        .id_needs_operands(id_needs_operands), .jump_taken(jump_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    endtask

    task automatic idle();
        idex_reg_write = 0; idex_mem_read = 0; idex_rd = '0;
        exmem_mem_read = 0; exmem_rd = '0; ifid_rs = '0; ifid_rs_used = '0;
        id_needs_operands = 0; jump_taken = 0; mem_req = 0; mem_ready = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: flush_left = flush cycles still owed after a redirect,
    // consec = consecutive freeze cycles, counters as unbounded integers.
    int m_flush_left, m_consec, m_stl, m_frz;
    bit m_to;

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    always @(negedge clk) begin
        bit hx, hm, st, fz, jmp_ok;
        int e_pc, e_ifid, e_idex, e_exm, e_bub, e_fl;
        if (reset) begin
            m_flush_left = 0; m_consec = 0; m_stl = 0; m_frz = 0; m_to = 0;
        end
        hx = 0; hm = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ifid_rs_used[i] && idex_rd != 0 && ifid_rs[i*REG_AW +: REG_AW] == idex_rd) hx = 1;
            if (ifid_rs_used[i] && exmem_rd != 0 && ifid_rs[i*REG_AW +: REG_AW] == exmem_rd) hm = 1;
        end
        st = (idex_mem_read && hx) ||
             (id_needs_operands && ((idex_reg_write && hx) || (exmem_mem_read && hm)));
        fz = mem_req && !mem_ready;
        jmp_ok = !fz && !st && jump_taken;
        e_pc = !fz && !st; e_ifid = e_pc; e_idex = !fz; e_exm = !fz;
        e_bub = !fz && st;
        e_fl = !fz && !st && (jump_taken || m_flush_left > 0);
        chk("pc_write", pc_write, e_pc);
        chk("ifid_write", ifid_write, e_ifid);
        chk("idex_write", idex_write, e_idex);
        chk("exmem_write", exmem_write, e_exm);
        chk("idex_bubble", idex_bubble, e_bub);
        chk("ifid_flush", ifid_flush, e_fl);
        chk("mem_timeout", mem_timeout, m_to);
        chk("stall_cycles", stall_cycles, sat(m_stl));
        chk("freeze_cycles", freeze_cycles, sat(m_frz));
        if (!reset) begin
            if (fz) begin
                m_frz++; m_consec++;
                if (m_consec >= MEM_TIMEOUT) m_to = 1;
            end else begin
                m_consec = 0;
                if (st) m_stl++;
                else if (jmp_ok) m_flush_left = IMEM_LAT;
                else if (m_flush_left > 0) m_flush_left--;
            end
        end
    end

    initial begin
        int nfl, burst;
        idle();
        #1 reset = 1;
        #2;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_exmem_write", exmem_write, 1);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        step();
        reset = 0;

        // Load-use on port 0
        idex_mem_read = 1; idex_rd = 5; ifid_rs = {5'd0, 5'd5}; ifid_rs_used = 2'b01;
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_bubble", idex_bubble, 1);
        step();
        idle();
        #1 chk("lu_stall_cnt", stall_cycles, 1);
        chk("lu_release", pc_write, 1);
        idex_mem_read = 1; idex_rd = 5; ifid_rs = {5'd0, 5'd5}; ifid_rs_used = 2'b00;
        #1 chk("lu_unused", pc_write, 1);

        // Branch hazards from EX then MEM, then x0
        step(); idle();
        idex_reg_write = 1; idex_rd = 3; id_needs_operands = 1;
        ifid_rs = {5'd3, 5'd0}; ifid_rs_used = 2'b10;
        #1 chk("br_ex_bubble", idex_bubble, 1);
        step(); idle();
        exmem_mem_read = 1; exmem_rd = 3; id_needs_operands = 1;
        ifid_rs = {5'd3, 5'd0}; ifid_rs_used = 2'b10;
        #1 chk("br_mem_bubble", idex_bubble, 1);
        step();
        exmem_rd = 0; ifid_rs = '0;
        #1 chk("br_x0", idex_bubble, 0);
        chk("br_stall_cnt", stall_cycles, 3);

        // Redirect: 1+IMEM_LAT flush cycles
        step(); idle(); nfl = 0;
        jump_taken = 1;
        for (int i = 0; i < 5; i++) begin
            #1 nfl += int'(ifid_flush);
            step(); jump_taken = 0;
        end
        chk("redir_flush_len", nfl, 3);

        // Redirect with a freeze on the second cycle
        nfl = 0;
        for (int i = 0; i < 6; i++) begin
            jump_taken = (i == 0);
            mem_req = (i == 1); mem_ready = (i != 1);
            #1 nfl += int'(ifid_flush);
            step();
        end
        idle();
        chk("redir_frz_flush_len", nfl, 3);
        chk("redir_frz_cnt", freeze_cycles, 1);

        // Freeze and timeout
        for (int i = 0; i < 6; i++) begin
            mem_req = 1; mem_ready = 0;
            #1 chk("frz_pc_write", pc_write, 0);
            chk("frz_timeout", mem_timeout, (i >= 4) ? 1 : 0);
            step();
        end
        mem_ready = 1;
        #1 chk("to_sticky", mem_timeout, 1);
        chk("to_frz_cnt", freeze_cycles, 7);

        // Priority: freeze beats load-use and redirect; stall beats redirect
        step(); idle();
        mem_req = 1; mem_ready = 0; jump_taken = 1;
        idex_mem_read = 1; idex_rd = 7; ifid_rs = {5'd0, 5'd7}; ifid_rs_used = 2'b01;
        #1 chk("pri_frz_bubble", idex_bubble, 0);
        chk("pri_frz_flush", ifid_flush, 0);
        chk("pri_frz_idex", idex_write, 0);
        step(); mem_ready = 1;
        #1 chk("pri_stall_bubble", idex_bubble, 1);
        chk("pri_stall_flush", ifid_flush, 0);
        step(); idle();
        #1 chk("pri_jump_dropped", ifid_flush, 0);

        // Reset mid-countdown and mid-wait
        step(); jump_taken = 1;
        step(); jump_taken = 0; mem_req = 1; mem_ready = 0;
        step();
        #1 reset = 1; idle();
        #1 chk("arst_flush", ifid_flush, 0);
        chk("arst_pc_write", pc_write, 1);
        chk("arst_timeout", mem_timeout, 0);
        chk("arst_frz_cnt", freeze_cycles, 0);
        chk("arst_stall_cnt", stall_cycles, 0);
        step(); reset = 0;
        #1 chk("post_rst_flush", ifid_flush, 0);

        // Randomized phase
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            step();
            reset = ($urandom_range(0, 599) == 0);
            idex_reg_write = 1'($urandom_range(0, 1));
            idex_mem_read = ($urandom_range(0, 3) == 0);
            idex_rd = 5'($urandom_range(0, 3));
            exmem_mem_read = ($urandom_range(0, 3) == 0);
            exmem_rd = 5'($urandom_range(0, 3));
            ifid_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ifid_rs_used = 2'($urandom_range(0, 3));
            id_needs_operands = 1'($urandom_range(0, 1));
            jump_taken = ($urandom_range(0, 3) == 0);
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(3, 8);
            if (burst > 0) begin
                mem_req = 1; mem_ready = 0; burst--;
            end else begin
                mem_req = 1'($urandom_range(0, 1));
                mem_ready = ($urandom_range(0, 2) != 0);
            end
        end
        step(); idle(); reset = 0;
        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
